// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the main-memory refill arbiter.
//   - arb_state_e : burst FSM states (idle, I-cache read, D-cache read/write)
//   - grant_e     : which cache owns (or last owned) the memory port
//   - WORD_BYTES  : bytes per memory beat
//   - off_bits()  : number of line-offset bits for a given line size in words
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IC_RD = 2'd1,
    DC_RD = 2'd2,
    DC_WR = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_e;

  localparam int WORD_BYTES = 4;

  // Line-offset width: word-index bits plus byte-in-word bits.
  function automatic int off_bits(input int block_words);
    return $clog2(block_words) + $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin pick between the I-cache and the D-cache.
//   When only one side requests it wins; when both request, the side that was
//   NOT served last wins.
// Ports
//   i_ic_req      I-cache request
//   i_dc_req      D-cache request
//   i_last_grant  side served by the previous burst (grant_e encoding)
//   o_gnt_valid   at least one request present
//   o_gnt         chosen side (grant_e encoding), meaningful when o_gnt_valid
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_ic_req,
  input  logic i_dc_req,
  input  logic i_last_grant,
  output logic o_gnt_valid,
  output logic o_gnt
);

  always_comb begin
    o_gnt_valid = i_ic_req | i_dc_req;
    o_gnt       = GNT_IC;
    if (i_ic_req && i_dc_req) begin
      // Contention: hand the port to whoever did not have it last time.
      o_gnt = (i_last_grant == GNT_IC) ? GNT_DC : GNT_IC;
    end else if (i_dc_req) begin
      o_gnt = GNT_DC;
    end else begin
      o_gnt = GNT_IC;
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// -----------------------------------------------------------------------------
// mem_refill_arbiter
//   Shares the single main-memory port between I-cache line refills and
//   D-cache refills / write-backs. One requester is granted at a time and a
//   BLOCK_WORDS-beat burst is sequenced with a beat counter. The stall outputs
//   feed the hazard unit and hold the pipeline while a miss is outstanding.
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   ic_req/ic_addr        I-cache line refill request and miss byte address
//   ic_rdata/ic_rvalid    refill word to the I-cache and its strobe
//   ic_done               pulse on the last I-cache beat
//   dc_req/dc_we/dc_addr  D-cache request, 1=write-back 0=refill, byte address
//   dc_wdata/dc_wready    write-back word; wready says it was consumed
//   dc_rdata/dc_rvalid    refill word to the D-cache and its strobe
//   dc_done               pulse on the last D-cache beat
//   mem_req/mem_we        memory beat request and direction
//   mem_addr/mem_wdata    beat byte address and write data
//   mem_rdata/mem_ready   read data and beat-complete handshake
//   IC_stall/DC_stall     request outstanding and not finishing this cycle
// -----------------------------------------------------------------------------
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              IC_stall,
  output logic              DC_stall
);

  localparam int OFF_W  = off_bits(BLOCK_WORDS);
  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int BYTE_W = $clog2(WORD_BYTES);

  // Clears the line-offset bits so every burst starts at word 0 of the line.
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  arb_state_e        r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [ADDR_W-1:0] r_base;
  grant_e            r_last_grant;

  logic              w_gnt_valid;
  logic              w_gnt;
  logic              w_busy;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_beat_off;

  rr_arb2 u_rr_arb2 (
    .i_ic_req     (ic_req),
    .i_dc_req     (dc_req),
    .i_last_grant (r_last_grant),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt        (w_gnt)
  );

  // ---------------------------------------------------------------------------
  // Burst FSM. Requests are only looked at in IDLE; once a burst starts the
  // captured base and direction (encoded in the state) are frozen until the
  // last beat, so requesters may change addr/we/req freely mid-burst.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_base       <= '0;
      r_last_grant <= GNT_IC;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat <= '0;
          if (w_gnt_valid) begin
            if (w_gnt == GNT_DC) begin
              r_state <= dc_we ? DC_WR : DC_RD;
              r_base  <= dc_addr & LINE_MASK;
            end else begin
              r_state <= IC_RD;
              r_base  <= ic_addr & LINE_MASK;
            end
          end
        end
        default: begin
          // mem_req is held until memory completes the beat.
          if (mem_ready) begin
            if (w_last_beat) begin
              r_beat       <= '0;
              r_state      <= IDLE;
              r_last_grant <= (r_state == IC_RD) ? GNT_IC : GNT_DC;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-side drive and per-requester response muxing. Strobes and done are
  // combinational on mem_ready so the cache sees data in the beat it arrives.
  // ---------------------------------------------------------------------------
  assign w_busy      = (r_state != IDLE);
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_beat_off  = ADDR_W'(r_beat) << BYTE_W;

  assign mem_req   = w_busy;
  assign mem_we    = (r_state == DC_WR);
  assign mem_addr  = w_busy ? (r_base + w_beat_off) : '0;
  assign mem_wdata = dc_wdata;

  assign ic_rvalid = (r_state == IC_RD) & mem_ready;
  assign dc_rvalid = (r_state == DC_RD) & mem_ready;
  assign dc_wready = (r_state == DC_WR) & mem_ready;

  // Read data is forced to zero outside a valid beat so idle buses stay quiet.
  assign ic_rdata = ic_rvalid ? mem_rdata : '0;
  assign dc_rdata = dc_rvalid ? mem_rdata : '0;

  assign ic_done = ic_rvalid & w_last_beat;
  assign dc_done = (dc_rvalid | dc_wready) & w_last_beat;

  assign IC_stall = ic_req & ~ic_done;
  assign DC_stall = dc_req & ~dc_done;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
module tb_mem_refill_arbiter;

  localparam int BW = 4;
  localparam logic [31:0] LMASK = ~32'(BW * 4 - 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic        dc_wready;
  logic [31:0] dc_rdata;
  logic        dc_rvalid;
  logic        dc_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        IC_stall;
  logic        DC_stall;

  mem_refill_arbiter #(.ADDR_W(32), .DATA_W(32), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wready(dc_wready),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .IC_stall(IC_stall), .DC_stall(DC_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model controls: 0 = zero-wait, 1 = ready every 3rd request cycle, 2 = random.
  int          ready_mode = 0;
  int          rdy_cnt = 0;
  int          widx = 0;
  bit          wadv = 1'b0;
  logic [31:0] wd_base = '0;
  int          m_last = 0;   // reference model: 0 = IC served last, 1 = DC

  typedef struct {
    logic req, rdy, we;
    logic [31:0] addr, wdata, dcw, ic_rd, dc_rd;
    logic ic_rv, dc_rv, dc_wr, ic_dn, dc_dn, ic_st, dc_st;
  } cyc_t;

  cyc_t trace[$];
  cyc_t beats[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Round-robin rule: single requester wins; on contention the side not served last wins.
  function automatic int predict(input logic ic, input logic dc);
    if (ic && dc) return (m_last == 0) ? 1 : 0;
    return dc ? 1 : 0;
  endfunction

  // D-cache write-back source: word index advances after each consumed word.
  always @(negedge clk) if (dc_wready === 1'b1) wadv = 1'b1;

  // Memory model, reset together with the DUT.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      rdy_cnt = 0;
      wadv    = 1'b0;
    end
    if (wadv) begin
      widx = widx + 1;
      wadv = 1'b0;
    end
    dc_wdata  = wd_base + 32'(widx);
    mem_rdata = mem_word(mem_addr);
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: begin
        mem_ready = 1'b0;
        if (mem_req) begin
          rdy_cnt = rdy_cnt + 1;
          if (rdy_cnt == 3) begin
            mem_ready = 1'b1;
            rdy_cnt   = 0;
          end
        end
      end
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Passive recorder: one entry per cycle until a done pulse or the budget runs out.
  task automatic collect_burst(input int budget, input int mutate_at, output int lat, output bit timeout);
    cyc_t r;
    int nb;
    trace.delete();
    beats.delete();
    lat = 0; timeout = 1'b1; nb = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      r.req = mem_req; r.rdy = mem_ready; r.we = mem_we; r.addr = mem_addr; r.wdata = mem_wdata;
      r.dcw = dc_wdata; r.ic_rd = ic_rdata; r.dc_rd = dc_rdata; r.ic_rv = ic_rvalid; r.dc_rv = dc_rvalid;
      r.dc_wr = dc_wready; r.ic_dn = ic_done; r.dc_dn = dc_done; r.ic_st = IC_stall; r.dc_st = DC_stall;
      trace.push_back(r);
      lat++;
      if (mem_req && mem_ready) begin
        beats.push_back(r);
        nb++;
        if (nb == mutate_at) begin
          dc_addr = $urandom;
          dc_req  = 1'b0;
          dc_we   = ~dc_we;
        end
      end
      if (ic_done || dc_done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ic_req = 1'b0; dc_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_last = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; ready_mode = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    n_checks++; if ({ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done} !== 5'b0) begin n_errors++; $display("FAIL reset_strobes got %b exp 00000", {ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done}); end
    n_checks++; if ({ic_rdata, dc_rdata} !== 64'h0) begin n_errors++; $display("FAIL reset_rdata got %h exp 0", {ic_rdata, dc_rdata}); end
    rst_n = 1'b1; m_last = 0;
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] base;
    int lat, nwr;
    bit to;
    @(negedge clk);
    ready_mode = 0; widx = 0; wadv = 1'b0; wd_base = 32'h1000_0000;
    dc_addr = 32'h0000_4014; dc_we = 1'b1; dc_req = 1'b1; base = 32'h0000_4010;
    repeat (3) @(negedge clk);
    n_checks++; if (mem_addr !== base + 32'd8) begin n_errors++; $display("FAIL rstmid_beat2_addr got %h exp %h", mem_addr, base + 32'd8); end
    n_checks++; if (dc_done !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_early_done got %b exp 0", dc_done); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL rstmid_mem_req got %b exp 0", mem_req); end
    n_checks++; if ({dc_done, dc_wready} !== 2'b00) begin n_errors++; $display("FAIL rstmid_no_done got %b exp 00", {dc_done, dc_wready}); end
    rst_n = 1'b1; m_last = 0;
    collect_burst(40, 0, lat, to);
    dc_req = 1'b0;
    nwr = 0;
    foreach (trace[i]) if (trace[i].dc_wr) nwr++;
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL rstmid_restart_timeout got %b exp 0", to); end
    n_checks++; if (beats.size() > 0 && beats[0].addr !== base) begin n_errors++; $display("FAIL rstmid_restart_beat0 got %h exp %h", beats[0].addr, base); end
    n_checks++; if (nwr != BW) begin n_errors++; $display("FAIL rstmid_restart_wready got %0d exp %0d", nwr, BW); end
    m_last = 1;
    $display("test_reset_mid_burst done: restart beats=%0d", beats.size());
  endtask

  task automatic test_ic_refill();
    int lat, nrv, ndn, nother;
    bit to;
    logic [31:0] ea;
    @(negedge clk);
    ready_mode = 0;
    ic_addr = 32'h0000_1234; ic_req = 1'b1;
    collect_burst(40, 0, lat, to);
    ic_req = 1'b0;
    nrv = 0; ndn = 0; nother = 0;
    foreach (trace[i]) begin
      if (trace[i].ic_rv) nrv++;
      if (trace[i].ic_dn) ndn++;
      if (trace[i].dc_rv || trace[i].dc_wr || trace[i].dc_dn) nother++;
    end
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL ic_timeout got %b exp 0", to); end
    // Counting the request cycle itself, req -> done spans 1+BW cycles.
    n_checks++; if (lat + 1 != 1 + BW) begin n_errors++; $display("FAIL ic_latency got %0d exp %0d", lat + 1, 1 + BW); end
    n_checks++; if (nrv != BW) begin n_errors++; $display("FAIL ic_rvalid_count got %0d exp %0d", nrv, BW); end
    n_checks++; if (ndn != 1) begin n_errors++; $display("FAIL ic_done_count got %0d exp 1", ndn); end
    n_checks++; if (nother != 0) begin n_errors++; $display("FAIL ic_dc_side_quiet got %0d exp 0", nother); end
    n_checks++; if (beats.size() != BW) begin n_errors++; $display("FAIL ic_beats got %0d exp %0d", beats.size(), BW); end
    for (int k = 0; k < beats.size(); k++) begin
      ea = 32'h0000_1230 + 32'(4 * k);
      n_checks++; if (beats[k].addr !== ea) begin n_errors++; $display("FAIL ic_addr_beat%0d got %h exp %h", k, beats[k].addr, ea); end
      n_checks++; if (beats[k].ic_rd !== mem_word(ea)) begin n_errors++; $display("FAIL ic_data_beat%0d got %h exp %h", k, beats[k].ic_rd, mem_word(ea)); end
      n_checks++; if (beats[k].ic_dn !== (k == BW - 1)) begin n_errors++; $display("FAIL ic_done_beat%0d got %b exp %b", k, beats[k].ic_dn, (k == BW - 1)); end
    end
    n_checks++; if (trace.size() > 0 && trace[0].ic_st !== 1'b1) begin n_errors++; $display("FAIL ic_stall_during got %b exp 1", trace[0].ic_st); end
    @(negedge clk);
    n_checks++; if (IC_stall !== 1'b0) begin n_errors++; $display("FAIL ic_stall_after got %b exp 0", IC_stall); end
    m_last = 0;
    $display("test_ic_refill done: lat=%0d beats=%0d", lat, beats.size());
  endtask

  task automatic test_contention();
    bit pic[5];
    bit pdc[5];
    int pred, srv, lat;
    bit to;
    logic [31:0] eb;
    pic = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    pdc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    ready_mode = 2; dc_we = 1'b0;
    ic_addr = $urandom; dc_addr = $urandom;
    ic_req = pic[0]; dc_req = pdc[0];
    for (int i = 0; i < 5; i++) begin
      pred = predict(ic_req, dc_req);
      eb = (pred == 1 ? dc_addr : ic_addr) & LMASK;
      collect_burst(300, 0, lat, to);
      srv = (beats.size() > 0 && (beats[0].dc_rv || beats[0].dc_wr)) ? 1 : 0;
      n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL cont%0d_timeout got %b exp 0", i, to); end
      n_checks++; if (srv != pred) begin n_errors++; $display("FAIL cont%0d_winner got %0d exp %0d", i, srv, pred); end
      n_checks++; if (beats.size() != BW) begin n_errors++; $display("FAIL cont%0d_beats got %0d exp %0d", i, beats.size(), BW); end
      n_checks++; if (beats.size() > 0 && beats[0].addr !== eb) begin n_errors++; $display("FAIL cont%0d_base got %h exp %h", i, beats[0].addr, eb); end
      m_last = pred;
      ic_addr = $urandom; dc_addr = $urandom;
      if (i < 4) begin
        ic_req = pic[i + 1]; dc_req = pdc[i + 1];
      end else begin
        ic_req = 1'b0; dc_req = 1'b0;
      end
      $display("test_contention step %0d: served=%s", i, pred == 1 ? "DC" : "IC");
    end
  endtask

  task automatic test_dc_writeback();
    int lat, nwr, nwe_bad, nwd_bad, nstab_bad;
    bit to;
    logic [31:0] ea;
    @(negedge clk);
    ready_mode = 1; rdy_cnt = 0; widx = 0; wadv = 1'b0; wd_base = $urandom;
    dc_addr = 32'h0000_8000; dc_we = 1'b1; dc_req = 1'b1;
    collect_burst(60, 0, lat, to);
    dc_req = 1'b0;
    nwr = 0; nwe_bad = 0; nwd_bad = 0; nstab_bad = 0;
    foreach (trace[i]) begin
      if (trace[i].dc_wr) nwr++;
      if (trace[i].we !== 1'b1) nwe_bad++;
      if (trace[i].wdata !== trace[i].dcw) nwd_bad++;
      if (i > 0 && !trace[i - 1].rdy && trace[i].addr !== trace[i - 1].addr) nstab_bad++;
    end
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL wb_timeout got %b exp 0", to); end
    n_checks++; if (lat != 3 * BW) begin n_errors++; $display("FAIL wb_cycles got %0d exp %0d", lat, 3 * BW); end
    n_checks++; if (nwr != BW) begin n_errors++; $display("FAIL wb_wready_count got %0d exp %0d", nwr, BW); end
    n_checks++; if (nwe_bad != 0) begin n_errors++; $display("FAIL wb_mem_we got %0d bad cycles exp 0", nwe_bad); end
    n_checks++; if (nwd_bad != 0) begin n_errors++; $display("FAIL wb_wdata_track got %0d bad cycles exp 0", nwd_bad); end
    n_checks++; if (nstab_bad != 0) begin n_errors++; $display("FAIL wb_addr_stable got %0d bad cycles exp 0", nstab_bad); end
    for (int k = 0; k < beats.size(); k++) begin
      ea = 32'h0000_8000 + 32'(4 * k);
      n_checks++; if (beats[k].addr !== ea) begin n_errors++; $display("FAIL wb_addr_beat%0d got %h exp %h", k, beats[k].addr, ea); end
      n_checks++; if (beats[k].wdata !== wd_base + 32'(k)) begin n_errors++; $display("FAIL wb_data_beat%0d got %h exp %h", k, beats[k].wdata, wd_base + 32'(k)); end
    end
    m_last = 1;
    $display("test_dc_writeback done: cycles=%0d wready=%0d", lat, nwr);
  endtask

  task automatic test_addr_change();
    int lat, nrv;
    bit to;
    logic [31:0] eb, ea;
    @(negedge clk);
    ready_mode = 2; dc_we = 1'b0;
    dc_addr = $urandom; eb = dc_addr & LMASK; dc_req = 1'b1;
    collect_burst(300, 2, lat, to);
    dc_req = 1'b0;
    nrv = 0;
    foreach (trace[i]) if (trace[i].dc_rv) nrv++;
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL chg_done_missing got timeout=%b exp 0", to); end
    n_checks++; if (nrv != BW) begin n_errors++; $display("FAIL chg_rvalid_count got %0d exp %0d", nrv, BW); end
    for (int k = 0; k < beats.size(); k++) begin
      ea = eb + 32'(4 * k);
      n_checks++; if (beats[k].addr !== ea) begin n_errors++; $display("FAIL chg_addr_beat%0d got %h exp %h", k, beats[k].addr, ea); end
      n_checks++; if (beats[k].we !== 1'b0) begin n_errors++; $display("FAIL chg_we_beat%0d got %b exp 0", k, beats[k].we); end
    end
    dc_we = 1'b0;
    m_last = 1;
    $display("test_addr_change done: beats=%0d", beats.size());
  endtask

  task automatic test_back_to_back();
    int lat;
    bit to;
    logic [31:0] ya;
    @(negedge clk);
    ready_mode = 0; dc_we = 1'b0;
    dc_addr = 32'h0000_2008; dc_req = 1'b1;
    collect_burst(40, 0, lat, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL b2b_first_timeout got %b exp 0", to); end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_gap got %b exp 0", mem_req); end
    n_checks++; if (DC_stall !== 1'b1) begin n_errors++; $display("FAIL b2b_stall_gap got %b exp 1", DC_stall); end
    ya = 32'hFFFF_FFF4;   // last line of the address space
    dc_addr = ya;
    collect_burst(40, 0, lat, to);
    dc_req = 1'b0;
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL b2b_second_timeout got %b exp 0", to); end
    n_checks++; if (lat != BW) begin n_errors++; $display("FAIL b2b_second_latency got %0d exp %0d", lat, BW); end
    for (int k = 0; k < beats.size(); k++) begin
      n_checks++; if (beats[k].addr !== (ya & LMASK) + 32'(4 * k)) begin n_errors++; $display("FAIL b2b_addr_beat%0d got %h exp %h", k, beats[k].addr, (ya & LMASK) + 32'(4 * k)); end
    end
    m_last = 1;
    $display("test_back_to_back done: second lat=%0d", lat);
  endtask

  task automatic test_random();
    int pred, srv, lat, nother, nloser_bad;
    bit to, wr, both;
    logic [31:0] eb, ea, got, expd;
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      ready_mode = $urandom_range(0, 2); rdy_cnt = 0; widx = 0; wadv = 1'b0; wd_base = $urandom;
      ic_addr = $urandom; dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1));
      ic_req = 1'($urandom_range(0, 1));
      dc_req = ic_req ? 1'($urandom_range(0, 1)) : 1'b1;
      both = ic_req & dc_req;
      pred = predict(ic_req, dc_req);
      wr = (pred == 1) && dc_we;
      eb = (pred == 1 ? dc_addr : ic_addr) & LMASK;
      collect_burst(300, 0, lat, to);
      ic_req = 1'b0; dc_req = 1'b0;
      srv = (beats.size() > 0 && (beats[0].dc_rv || beats[0].dc_wr)) ? 1 : 0;
      nother = 0; nloser_bad = 0;
      foreach (trace[i]) begin
        if (pred == 1 && (trace[i].ic_rv || trace[i].ic_dn)) nother++;
        if (pred == 0 && (trace[i].dc_rv || trace[i].dc_wr || trace[i].dc_dn)) nother++;
        if (both && (pred == 1 ? trace[i].ic_st : trace[i].dc_st) !== 1'b1) nloser_bad++;
      end
      n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_timeout got %b exp 0", it, to); end
      n_checks++; if (srv != pred) begin n_errors++; $display("FAIL rnd%0d_winner got %0d exp %0d", it, srv, pred); end
      n_checks++; if (beats.size() != BW) begin n_errors++; $display("FAIL rnd%0d_beats got %0d exp %0d", it, beats.size(), BW); end
      n_checks++; if (nother != 0) begin n_errors++; $display("FAIL rnd%0d_other_side got %0d exp 0", it, nother); end
      n_checks++; if (nloser_bad != 0) begin n_errors++; $display("FAIL rnd%0d_loser_stall got %0d bad exp 0", it, nloser_bad); end
      for (int k = 0; k < beats.size(); k++) begin
        ea = eb + 32'(4 * k);
        n_checks++; if (beats[k].addr !== ea) begin n_errors++; $display("FAIL rnd%0d_addr_beat%0d got %h exp %h", it, k, beats[k].addr, ea); end
        n_checks++; if (beats[k].we !== wr) begin n_errors++; $display("FAIL rnd%0d_we_beat%0d got %b exp %b", it, k, beats[k].we, wr); end
        if (wr) begin
          got = beats[k].wdata; expd = wd_base + 32'(k);
        end else begin
          got = (pred == 1) ? beats[k].dc_rd : beats[k].ic_rd; expd = mem_word(ea);
        end
        n_checks++; if (got !== expd) begin n_errors++; $display("FAIL rnd%0d_data_beat%0d got %h exp %h", it, k, got, expd); end
        n_checks++; if (((pred == 1) ? beats[k].dc_dn : beats[k].ic_dn) !== (k == BW - 1)) begin n_errors++; $display("FAIL rnd%0d_done_beat%0d got %b exp %b", it, k, ((pred == 1) ? beats[k].dc_dn : beats[k].ic_dn), (k == BW - 1)); end
      end
      m_last = pred;
      $display("test_random %0d: mode=%0d served=%s we=%b base=%h cycles=%0d", it, ready_mode, pred == 1 ? "DC" : "IC", wr, eb, lat);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_ic_refill();
    test_contention();
    test_dc_writeback();
    test_addr_change();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
